// File: rtl/count_monitor.sv
// Sequence checker for a 4-bit up-counter: tracks +1 steps, counts 15->0 wraps,
// flags stalls after STALL_LIMIT repeats and latches illegal jumps until acknowledged.
module count_monitor #(
  parameter int unsigned STALL_LIMIT = 8,
  parameter int unsigned WRAP_W      = 8
) (
  input  logic              clock,
  input  logic              clear,
  input  logic [3:0]        count_in,
  input  logic              up_clear,
  input  logic              err_ack,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wrap_count,
  output logic              stall,
  output logic              seq_error,
  output logic [1:0]        state
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned SCNT_W = 8;
  localparam logic [SCNT_W-1:0] LIMIT    = SCNT_W'(STALL_LIMIT);
  localparam logic [WRAP_W-1:0] WRAP_MAX = '1;
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    STALL = 2'd2,
    FAULT = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    prev_q, prev_d;
  logic [SCNT_W-1:0]   scnt_q, scnt_d;
  logic [WRAP_W-1:0]   wrap_cnt_q, wrap_cnt_d;
  logic                pulse_q, pulse_d;
  logic                stall_q, stall_d;
  logic                err_q, err_d;

  logic [CNT_W-1:0]    delta;
  logic [SCNT_W-1:0]   scnt_inc;

  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    scnt_d     = scnt_q;
    wrap_cnt_d = wrap_cnt_q;
    pulse_d    = 1'b0;
    stall_d    = stall_q;
    err_d      = err_q;
    delta      = count_in - prev_q;
    scnt_inc   = scnt_q + SCNT_W'(1);

    unique case (state_q)
      IDLE: begin
        scnt_d  = '0;
        stall_d = 1'b0;
        state_d = TRACK;
      end
      TRACK, STALL: begin
        // upstream clear outranks delta evaluation
        if (up_clear) begin
          stall_d = 1'b0;
          if (count_in == '0) begin
            state_d = TRACK;
            scnt_d  = '0;
          end else begin
            state_d = FAULT;
            err_d   = 1'b1;
          end
        end else if (delta == CNT_W'(1)) begin
          state_d = TRACK;
          scnt_d  = '0;
          stall_d = 1'b0;
          if (prev_q == CNT_MAX) begin
            pulse_d = 1'b1;
            if (wrap_cnt_q != WRAP_MAX) wrap_cnt_d = wrap_cnt_q + WRAP_W'(1);
          end
        end else if (delta == '0) begin
          if (state_q == TRACK) begin
            scnt_d = scnt_inc;
            if (scnt_inc == LIMIT) begin
              state_d = STALL;
              stall_d = 1'b1;
            end
          end
        end else begin
          state_d = FAULT;
          stall_d = 1'b0;
          err_d   = 1'b1;
        end
      end
      FAULT: begin
        if (err_ack) begin
          state_d    = IDLE;
          err_d      = 1'b0;
          wrap_cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    // the faulting sample is not trusted as a new reference
    if (state_q != FAULT) prev_d = count_in;
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q    <= IDLE;
      prev_q     <= '0;
      scnt_q     <= '0;
      wrap_cnt_q <= '0;
      pulse_q    <= 1'b0;
      stall_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      scnt_q     <= scnt_d;
      wrap_cnt_q <= wrap_cnt_d;
      pulse_q    <= pulse_d;
      stall_q    <= stall_d;
      err_q      <= err_d;
    end
  end

  assign wrap_pulse = pulse_q;
  assign wrap_count = wrap_cnt_q;
  assign stall      = stall_q;
  assign seq_error  = err_q;
  assign state      = state_q;

endmodule

// File: tb/tb_count_monitor.sv
// Bench for count_monitor: directed vector table, saturation and async reset
// sequences, then random stimulus against a rule-level reference model.
module tb_count_monitor;

  localparam int unsigned LIMIT = 8;
  localparam int unsigned W1    = 8;
  localparam int unsigned W2    = 2;

  logic          clock = 1'b0;
  logic          clear;
  logic [3:0]    count_in;
  logic          up_clear;
  logic          err_ack;

  logic          wp1, stl1, se1;
  logic [W1-1:0] wc1;
  logic [1:0]    sta1;
  logic          wp2, stl2, se2;
  logic [W2-1:0] wc2;
  logic [1:0]    sta2;

  always #5 clock = ~clock;

  count_monitor #(.STALL_LIMIT(LIMIT), .WRAP_W(W1)) dut (
    .clock(clock), .clear(clear), .count_in(count_in), .up_clear(up_clear), .err_ack(err_ack),
    .wrap_pulse(wp1), .wrap_count(wc1), .stall(stl1), .seq_error(se1), .state(sta1));

  count_monitor #(.STALL_LIMIT(LIMIT), .WRAP_W(W2)) dut2 (
    .clock(clock), .clear(clear), .count_in(count_in), .up_clear(up_clear), .err_ack(err_ack),
    .wrap_pulse(wp2), .wrap_count(wc2), .stall(stl2), .seq_error(se2), .state(sta2));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0..3 = idle/track/stall/fault, run = repeats of current value,
  // wraps = unbounded wrap total (each DUT shows it clipped to its own width).
  int m_mode, m_prev, m_run, m_wraps, m_pulse;

  function automatic int sat(input int v, input int w);
    int m;
    m = (1 << w) - 1;
    return (v > m) ? m : v;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_prev = 0; m_run = 0; m_wraps = 0; m_pulse = 0;
  endtask

  task automatic model_edge(input int c, input int uc, input int ack);
    int old_mode, step;
    old_mode = m_mode;
    step     = (c - m_prev + 16) % 16;
    m_pulse  = 0;
    if (m_mode == 0) begin
      m_mode = 1; m_run = 0;
    end else if (m_mode == 3) begin
      if (ack != 0) begin m_mode = 0; m_wraps = 0; end
    end else if (uc != 0) begin
      if (c == 0) begin m_mode = 1; m_run = 0; end
      else m_mode = 3;
    end else if (step == 1) begin
      if (m_prev == 15) begin m_pulse = 1; m_wraps++; end
      m_mode = 1; m_run = 0;
    end else if (step == 0) begin
      if (m_mode == 1) begin
        m_run++;
        if (m_run == int'(LIMIT)) m_mode = 2;
      end
    end else begin
      m_mode = 3;
    end
    if (old_mode != 3) m_prev = c;
  endtask

  task automatic check_model();
    chk("state",      int'(sta1), m_mode);
    chk("wrap_pulse", int'(wp1),  m_pulse);
    chk("stall",      int'(stl1), (m_mode == 2) ? 1 : 0);
    chk("seq_error",  int'(se1),  (m_mode == 3) ? 1 : 0);
    chk("wrap_count", int'(wc1),  sat(m_wraps, W1));
    chk("state2",     int'(sta2), m_mode);
    chk("wrap_count2",int'(wc2),  sat(m_wraps, W2));
  endtask

  task automatic step(input logic [3:0] c, input logic uc, input logic ack);
    count_in = c; up_clear = uc; err_ack = ack;
    @(posedge clock);
    model_edge(int'(c), int'(uc), int'(ack));
    #1;
    check_model();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " state"},      int'(sta1), 0);
    chk({tag, " wrap_pulse"}, int'(wp1),  0);
    chk({tag, " stall"},      int'(stl1), 0);
    chk({tag, " seq_error"},  int'(se1),  0);
    chk({tag, " wrap_count"}, int'(wc1),  0);
    chk({tag, " wrap_count2"},int'(wc2),  0);
    chk({tag, " state2"},     int'(sta2), 0);
  endtask

  typedef struct {
    logic [3:0] c;
    logic       uc;
    logic       ack;
    int         st;
    int         pl;
    int         stl;
    int         er;
    int         wc;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input int c, input int uc, input int ack,
                              input int st, input int pl, input int stl, input int er, input int wc);
    vec_t v;
    v.c = 4'(c); v.uc = 1'(uc); v.ack = 1'(ack);
    v.st = st; v.pl = pl; v.stl = stl; v.er = er; v.wc = wc;
    tbl.push_back(v);
  endfunction

  initial begin
    logic [3:0] last;
    int streak;

    // free run: 0..15,0..15,0
    for (int i = 0; i <= 32; i++)
      add(i % 16, 0, 0, 1, (i == 16 || i == 32) ? 1 : 0, 0, 0, (i >= 32) ? 2 : (i >= 16) ? 1 : 0);
    // jump 3->7 faults, wrap_count frozen, ack returns to idle and clears it
    add(1, 0, 0, 1, 0, 0, 0, 2);
    add(2, 0, 1, 1, 0, 0, 0, 2);
    add(3, 0, 0, 1, 0, 0, 0, 2);
    add(7, 0, 0, 3, 0, 0, 1, 2);
    add(8, 0, 0, 3, 0, 0, 1, 2);
    add(9, 0, 1, 0, 0, 0, 0, 0);
    // stall after eight repeats of 5, released by 6
    add(4, 0, 0, 1, 0, 0, 0, 0);
    add(5, 0, 0, 1, 0, 0, 0, 0);
    for (int i = 1; i <= int'(LIMIT); i++)
      add(5, 0, 0, (i == int'(LIMIT)) ? 2 : 1, 0, (i == int'(LIMIT)) ? 1 : 0, 0, 0);
    add(5, 0, 0, 2, 0, 1, 0, 0);
    add(6, 0, 0, 1, 0, 0, 0, 0);
    // upstream clear: 9->0 legal without wrap, 9->2 faults
    add(7, 0, 0, 1, 0, 0, 0, 0);
    add(8, 0, 0, 1, 0, 0, 0, 0);
    add(9, 0, 0, 1, 0, 0, 0, 0);
    add(0, 1, 0, 1, 0, 0, 0, 0);
    for (int i = 1; i <= 9; i++) add(i, 0, 0, 1, 0, 0, 0, 0);
    add(2, 1, 0, 3, 0, 0, 1, 0);
    add(3, 0, 1, 0, 0, 0, 0, 0);

    // reset held with random inputs
    clear = 1'b0; count_in = '0; up_clear = 1'b0; err_ack = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      count_in = 4'($urandom); up_clear = 1'($urandom); err_ack = 1'($urandom);
      @(posedge clock); #1;
      check_all_zero("reset");
    end
    @(negedge clock);
    clear = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].c, tbl[i].uc, tbl[i].ack);
      chk($sformatf("vec%0d state", i),      int'(sta1), tbl[i].st);
      chk($sformatf("vec%0d wrap_pulse", i), int'(wp1),  tbl[i].pl);
      chk($sformatf("vec%0d stall", i),      int'(stl1), tbl[i].stl);
      chk($sformatf("vec%0d seq_error", i),  int'(se1),  tbl[i].er);
      chk($sformatf("vec%0d wrap_count", i), int'(wc1),  tbl[i].wc);
      chk($sformatf("vec%0d wrap_count2", i),int'(wc2),  (tbl[i].wc > 3) ? 3 : tbl[i].wc);
    end

    // five wraps: wide counter reads 5, narrow one saturates at 3
    step(4'd0, 1'b0, 1'b0);
    for (int w = 0; w < 5; w++)
      for (int v = 1; v <= 16; v++) step(4'(v % 16), 1'b0, 1'b0);
    chk("sat wide",   int'(wc1), 5);
    chk("sat narrow", int'(wc2), 3);

    // asynchronous reset in the middle of a clock period
    step(4'd1, 1'b0, 1'b0);
    step(4'd2, 1'b0, 1'b0);
    #2 clear = 1'b0;
    #1 check_all_zero("async");
    model_reset();
    @(negedge clock);
    clear = 1'b1;

    // random stimulus against the model
    last = '0;
    streak = 0;
    for (int n = 0; n < 1500; n++) begin
      logic [3:0] c;
      logic uc, ack;
      int r;
      r = int'($urandom_range(99));
      uc = 1'b0;
      if (streak > 0) begin
        c = last; streak--;
      end else if (r < 65) c = last + 4'd1;
      else if (r < 75) begin
        c = last; streak = int'($urandom_range(10, 5));
      end else if (r < 82) begin
        c = '0; uc = 1'b1;
      end else if (r < 88) begin
        c = 4'($urandom); uc = 1'($urandom);
      end else c = 4'($urandom);
      ack = (m_mode == 3) ? ($urandom_range(99) < 30) : ($urandom_range(99) < 10);
      step(c, uc, ack);
      last = c;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
